// File: rtl/ram_io_responder_pkg.sv
// ram_io_responder_pkg
// Shared constants and types for the RAM/I/O responder on the CPU memory bus.
// Contents:
//   MEM_WIDTH     - width of one bus byte
//   BUS_ADDR_BITS - width of the controller's byte address
//   IO_REGION     - value of addr[17:16] that selects the I/O window
//   IO_UART_DATA  - UART data register (write = TX push, read = RX pop)
//   IO_UART_STAT  - UART status register {6'b0, rx_empty, tx_empty}
//   mem_byte_t    - one bus byte
//   bus_addr_t    - one bus address
//   is_io()       - region decode helper
package ram_io_responder_pkg;

    localparam int MEM_WIDTH     = 8;
    localparam int BUS_ADDR_BITS = 18;

    typedef logic [MEM_WIDTH-1:0]     mem_byte_t;
    typedef logic [BUS_ADDR_BITS-1:0] bus_addr_t;

    localparam logic [1:0] IO_REGION    = 2'b11;
    localparam bus_addr_t  IO_UART_DATA = 18'h30000;
    localparam bus_addr_t  IO_UART_STAT = 18'h30004;

    // True when the address falls in the memory-mapped I/O window.
    function automatic logic is_io(input bus_addr_t addr);
        return addr[17:16] == IO_REGION;
    endfunction

endpackage

// File: rtl/ram_io_responder_if.sv
// ram_io_responder_if
// Memory bus between the CPU's memory controller (master) and the RAM/I/O
// responder (slave).
//   mem_a          - byte address (master -> slave)
//   mem_wr         - 1 = write, 0 = read (master -> slave)
//   mem_wdata      - write byte (master -> slave)
//   mem_rdata      - read byte, one cycle after the address (slave -> master)
//   io_buffer_full - UART TX path full; I/O stores stall (slave -> master)
interface ram_io_responder_if;
    import ram_io_responder_pkg::*;

    bus_addr_t mem_a;
    logic      mem_wr;
    mem_byte_t mem_wdata;
    mem_byte_t mem_rdata;
    logic      io_buffer_full;

    modport master (
        output mem_a, mem_wr, mem_wdata,
        input  mem_rdata, io_buffer_full
    );

    modport slave (
        input  mem_a, mem_wr, mem_wdata,
        output mem_rdata, io_buffer_full
    );

endinterface

// File: rtl/ram_io_responder_byte_fifo.sv
// ram_io_responder_byte_fifo
// Byte FIFO of 2^DEPTH_LOG entries with a show-ahead head byte. Used for both
// the UART transmit and receive paths.
//   clk, rst_in_n - clock, asynchronous active-low reset (empties the FIFO)
//   push, din     - write din when push is high and the FIFO is not full
//   pop, dout     - dout is the head byte; pop discards it when not empty
//   empty, full   - occupancy flags, derived from the registered count
//   count         - number of bytes held, 0 .. 2^DEPTH_LOG
module ram_io_responder_byte_fifo
    import ram_io_responder_pkg::*;
#(
    parameter int DEPTH_LOG = 4
) (
    input  logic               clk,
    input  logic               rst_in_n,
    input  logic               push,
    input  mem_byte_t          din,
    input  logic               pop,
    output mem_byte_t          dout,
    output logic               empty,
    output logic               full,
    output logic [DEPTH_LOG:0] count
);

    localparam int                 DEPTH      = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_COUNT = (DEPTH_LOG + 1)'(DEPTH);

    logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG:0]   count_q,  count_d;
    mem_byte_t            mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_COUNT);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: every variable gets its default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap naturally at DEPTH_LOG bits.
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; clearing the pointers already
    // empties the FIFO, and a resettable array could not map onto RAM cells.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/ram_io_responder.sv
// ram_io_responder
// Memory-side responder for the CPU RAM bus: a byte-wide synchronous RAM plus
// a UART I/O window at addr[17:16] == 2'b11 (TX FIFO push, RX FIFO pop, status).
//   clk, rst_in_n        - clock, asynchronous active-low reset
//   rdy_in               - global ready; low suppresses all I/O side effects
//   bus (slave)          - mem_a / mem_wr / mem_wdata in, mem_rdata /
//                          io_buffer_full out
//   tx_valid/data/ready  - byte stream to the UART transmitter
//   rx_valid/data/ready  - byte stream from the UART receiver
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_BITS  = 17,
    parameter int FIFO_DEPTH_LOG = 4
) (
    input  logic                      clk,
    input  logic                      rst_in_n,
    input  logic                      rdy_in,
    ram_io_responder_if.slave         bus,
    output logic                      tx_valid,
    output mem_byte_t                 tx_data,
    input  logic                      tx_ready,
    input  logic                      rx_valid,
    input  mem_byte_t                 rx_data,
    output logic                      rx_ready
);

    // ---------------- decode ----------------
    logic io, ram_wr, ram_rd, io_rd, io_ok;
    logic tx_push, rx_pop;

    logic                    tx_empty, tx_full, rx_empty, rx_full;
    mem_byte_t               rx_dout;
    logic [FIFO_DEPTH_LOG:0] tx_count, rx_count;

    assign io     = is_io(bus.mem_a);
    assign ram_wr = bus.mem_wr && !io;
    assign ram_rd = !bus.mem_wr && !io;
    assign io_rd  = !bus.mem_wr && io;
    // A stalled controller holds its request, so side effects fire only once
    // the stall clears; otherwise a held store or load would repeat.
    assign io_ok  = rdy_in && !tx_full;

    assign tx_push = io && bus.mem_wr && (bus.mem_a == IO_UART_DATA) && io_ok;
    assign rx_pop  = io_rd && (bus.mem_a == IO_UART_DATA) && io_ok && !rx_empty;

    // ---------------- UART FIFOs ----------------
    ram_io_responder_byte_fifo #(.DEPTH_LOG(FIFO_DEPTH_LOG)) u_tx_fifo (
        .clk      (clk),
        .rst_in_n (rst_in_n),
        .push     (tx_push),
        .din      (bus.mem_wdata),
        .pop      (tx_ready),
        .dout     (tx_data),
        .empty    (tx_empty),
        .full     (tx_full),
        .count    (tx_count)
    );

    ram_io_responder_byte_fifo #(.DEPTH_LOG(FIFO_DEPTH_LOG)) u_rx_fifo (
        .clk      (clk),
        .rst_in_n (rst_in_n),
        .push     (rx_valid),
        .din      (rx_data),
        .pop      (rx_pop),
        .dout     (rx_dout),
        .empty    (rx_empty),
        .full     (rx_full),
        .count    (rx_count)
    );

    // Counts are exported for debug visibility only.
    logic unused_fifo_counts;
    assign unused_fifo_counts = ^{tx_count, rx_count};

    assign tx_valid           = !tx_empty;
    assign rx_ready           = !rx_full;
    assign bus.io_buffer_full = tx_full;

    // ---------------- RAM ----------------
    mem_byte_t ram [2**RAM_ADDR_BITS];
    mem_byte_t ram_rdata_q;

    // Writes are not gated by the stall: repeating a held RAM store is harmless.
    always_ff @(posedge clk) begin
        if (ram_wr) ram[bus.mem_a[RAM_ADDR_BITS-1:0]] <= bus.mem_wdata;
        if (ram_rd) ram_rdata_q <= ram[bus.mem_a[RAM_ADDR_BITS-1:0]];
    end

    // ---------------- I/O read data and read-source select ----------------
    // The RAM read register carries no reset, so the output is a registered
    // select between it and a resettable I/O data register. Reset selects the
    // I/O side, which makes mem_rdata read 0 out of reset.
    mem_byte_t io_rdata_q, io_rdata_d;
    logic      sel_io_q,   sel_io_d;

    always_comb begin
        io_rdata_d = io_rdata_q;
        sel_io_d   = sel_io_q;
        if (io_rd) begin
            sel_io_d = 1'b1;
            // While io_ok is low this still returns the head byte: a peek.
            if (bus.mem_a == IO_UART_DATA)
                io_rdata_d = rx_empty ? '0 : rx_dout;
            else if (bus.mem_a == IO_UART_STAT)
                io_rdata_d = {6'b0, rx_empty, tx_empty};
            else
                io_rdata_d = '0;
        end else if (ram_rd) begin
            sel_io_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            io_rdata_q <= '0;
            sel_io_q   <= 1'b1;
        end else begin
            io_rdata_q <= io_rdata_d;
            sel_io_q   <= sel_io_d;
        end
    end

    assign bus.mem_rdata = sel_io_q ? io_rdata_q : ram_rdata_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// tb_ram_io_responder
// Directed testbench for ram_io_responder: RAM access, UART TX/RX through the
// I/O window, full-FIFO stall, pointer wrap and asynchronous reset.
module tb_ram_io_responder;
    import ram_io_responder_pkg::*;

    logic      clk = 1'b0;
    logic      rst_in_n;
    logic      rdy_in;
    logic      tx_valid;
    mem_byte_t tx_data;
    logic      tx_ready;
    logic      rx_valid;
    mem_byte_t rx_data;
    logic      rx_ready;

    int n_checks = 0;
    int n_errors = 0;

    ram_io_responder_if bus_if ();

    ram_io_responder dut (
        .clk      (clk),
        .rst_in_n (rst_in_n),
        .rdy_in   (rdy_in),
        .bus      (bus_if),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus_if.mem_a     = 18'h00000;
        bus_if.mem_wr    = 1'b0;
        bus_if.mem_wdata = 8'h00;
    endtask

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic bus_write(input bus_addr_t a, input mem_byte_t d);
        bus_if.mem_a     = a;
        bus_if.mem_wr    = 1'b1;
        bus_if.mem_wdata = d;
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic bus_read(input bus_addr_t a, output mem_byte_t d);
        bus_if.mem_a  = a;
        bus_if.mem_wr = 1'b0;
        @(posedge clk); #1;
        d = bus_if.mem_rdata;
        bus_idle();
    endtask

    function automatic mem_byte_t wrap_byte(input int k);
        return 8'(k * 37 + 5);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_byte_t rd;
        mem_byte_t sweep [4];
        int sent, recv, cycles;
        logic pushed;

        rst_in_n = 1'b0;
        rdy_in   = 1'b1;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        bus_idle();
        repeat (2) @(posedge clk);
        #1;
        rst_in_n = 1'b1;

        // Reset values
        check("rst_mem_rdata", bus_if.mem_rdata, 8'h00);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_io_full", bus_if.io_buffer_full, 1'b0);
        check("rst_rx_ready", rx_ready, 1'b1);

        // RAM write then read-back
        bus_write(18'h00010, 8'hA5);
        bus_read(18'h00010, rd);
        check("ram_rd_after_wr", rd, 8'hA5);

        // Pipelined read sweep of four addresses
        sweep = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) bus_write(18'h00020 + 18'(i), sweep[i]);
        for (int i = 0; i < 4; i++) begin
            bus_if.mem_a  = 18'h00020 + 18'(i);
            bus_if.mem_wr = 1'b0;
            @(posedge clk); #1;
            check("ram_sweep", bus_if.mem_rdata, sweep[i]);
        end
        bus_idle();

        // Unmapped I/O address: read 0, write ignored
        bus_read(18'h30008, rd);
        check("io_unmapped_rd", rd, 8'h00);
        bus_write(18'h30008, 8'h55);
        check("io_unmapped_wr", tx_valid, 1'b0);

        // rdy_in low suppresses a TX push
        rdy_in = 1'b0;
        bus_write(IO_UART_DATA, 8'h77);
        rdy_in = 1'b1;
        check("rdy_gate_tx", tx_valid, 1'b0);

        // TX push and drain
        bus_write(IO_UART_DATA, 8'h41);
        check("tx_valid_push", tx_valid, 1'b1);
        check("tx_data_push", tx_data, 8'h41);
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        check("tx_valid_drain", tx_valid, 1'b0);
        bus_read(IO_UART_STAT, rd);
        check("stat_both_empty", rd, 8'h03);

        // Full stall: 16 pushes fill the FIFO, a held store waits
        for (int i = 0; i < 16; i++) bus_write(IO_UART_DATA, 8'(i));
        check("full_after_16", bus_if.io_buffer_full, 1'b1);
        check("full_head", tx_data, 8'h00);
        bus_if.mem_a     = IO_UART_DATA;
        bus_if.mem_wr    = 1'b1;
        bus_if.mem_wdata = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("full_held", bus_if.io_buffer_full, 1'b1);
        end
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        check("full_drop_after_pop", bus_if.io_buffer_full, 1'b0);
        @(posedge clk); #1;
        check("full_held_pushed", bus_if.io_buffer_full, 1'b1);
        bus_idle();
        tx_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("full_drain_order", tx_data, (k < 15) ? 8'(k + 1) : 8'hEE);
            @(posedge clk); #1;
        end
        tx_ready = 1'b0;
        check("full_drained_empty", tx_valid, 1'b0);

        // RX: two bytes in, peek while stalled, pop twice, then underflow read
        rx_valid = 1'b1;
        rx_data  = 8'h31;
        @(posedge clk); #1;
        rx_data  = 8'h32;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        bus_read(IO_UART_STAT, rd);
        check("stat_rx_avail", rd, 8'h01);
        rdy_in = 1'b0;
        bus_read(IO_UART_DATA, rd);
        rdy_in = 1'b1;
        check("rx_peek", rd, 8'h31);
        bus_read(IO_UART_DATA, rd);
        check("rx_pop_1", rd, 8'h31);
        bus_read(IO_UART_DATA, rd);
        check("rx_pop_2", rd, 8'h32);
        bus_read(IO_UART_DATA, rd);
        check("rx_pop_empty", rd, 8'h00);
        bus_read(IO_UART_STAT, rd);
        check("stat_rx_empty", rd, 8'h03);
        check("rx_ready_idle", rx_ready, 1'b1);

        // Wrap: 40 bytes through TX with tx_ready toggling every cycle
        sent   = 0;
        recv   = 0;
        cycles = 0;
        while (recv < 40 && cycles < 1000) begin
            if (sent < 40) begin
                bus_if.mem_a     = IO_UART_DATA;
                bus_if.mem_wr    = 1'b1;
                bus_if.mem_wdata = wrap_byte(sent);
            end else begin
                bus_idle();
            end
            tx_ready = cycles[0];
            pushed   = (sent < 40) && !bus_if.io_buffer_full;
            if (tx_valid && tx_ready) begin
                check("wrap_order", tx_data, wrap_byte(recv));
                recv++;
            end
            @(posedge clk); #1;
            if (pushed) sent++;
            cycles++;
        end
        bus_idle();
        tx_ready = 1'b0;
        check("wrap_received", recv, 40);
        check("wrap_empty", tx_valid, 1'b0);

        // Asynchronous reset with bytes queued
        for (int i = 0; i < 5; i++) bus_write(IO_UART_DATA, 8'h60 + 8'(i));
        check("rst_pre_valid", tx_valid, 1'b1);
        #3;
        rst_in_n = 1'b0;
        #1;
        check("rst_async_tx_valid", tx_valid, 1'b0);
        check("rst_async_full", bus_if.io_buffer_full, 1'b0);
        check("rst_async_rdata", bus_if.mem_rdata, 8'h00);
        @(negedge clk);
        rst_in_n = 1'b1;
        @(posedge clk); #1;
        check("rst_post_tx_valid", tx_valid, 1'b0);
        bus_read(18'h00010, rd);
        check("rst_ram_kept", rd, 8'hA5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
